// File: rtl/my_reg_pipe.sv
// Elastic register pipeline: DEPTH valid-tagged stages with valid/ready on both
// ends, bubble collapsing, flush, global enable and registered occupancy.
module my_reg_pipe #(
  parameter int unsigned          DATA_W  = 21,
  parameter int unsigned          DEPTH   = 3,
  parameter logic [DATA_W-1:0]    RST_VAL = '0,
  parameter int unsigned          OCC_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              flush_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic [OCC_W-1:0]  occ_o
);

  logic [DEPTH-1:0]  vld_q;
  logic [DEPTH-1:0]  vld_d;
  logic [DATA_W-1:0] dat_q [DEPTH];
  logic [DATA_W-1:0] dat_d [DEPTH];
  logic [OCC_W-1:0]  occ_q;
  logic [OCC_W-1:0]  occ_d;

  logic              go;
  logic              m_fire;
  logic              s_fire;
  logic              room;
  logic [DEPTH-1:0]  adv;
  logic [DEPTH-1:0]  ld;

  // Advance chain ripples from the output back to the input; room means the
  // stage just examined is empty or emptying on this edge.
  always_comb begin
    go        = en_i & ~flush_i & ~rst_i;
    m_valid_o = vld_q[DEPTH-1] & go;
    m_fire    = m_valid_o & m_ready_i;
    adv       = '0;
    adv[DEPTH-1] = m_fire;
    room      = ~vld_q[DEPTH-1] | m_fire;
    for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
      adv[k] = go & vld_q[k] & room;
      room   = ~vld_q[k] | (go & room);
    end
    s_ready_o = go & room;
    s_fire    = s_valid_i & s_ready_o;

    ld    = '0;
    ld[0] = s_fire;
    for (int k = 1; k < int'(DEPTH); k++) begin
      ld[k] = go & (~vld_q[k] | adv[k]) & vld_q[k-1];
    end

    // Data registers only move on a load; bubbles leave them untouched.
    vld_d = vld_q;
    for (int k = 0; k < int'(DEPTH); k++) begin
      dat_d[k] = dat_q[k];
      if (ld[k]) begin
        vld_d[k] = 1'b1;
      end else if (adv[k]) begin
        vld_d[k] = 1'b0;
      end
    end
    if (ld[0]) begin
      dat_d[0] = s_data_i;
    end
    for (int k = 1; k < int'(DEPTH); k++) begin
      if (ld[k]) begin
        dat_d[k] = dat_q[k-1];
      end
    end

    occ_d = occ_q + OCC_W'(s_fire) - OCC_W'(m_fire);
    if (flush_i) begin
      vld_d = '0;
      occ_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      occ_q <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        dat_q[k] <= RST_VAL;
      end
    end else begin
      vld_q <= vld_d;
      occ_q <= occ_d;
      for (int k = 0; k < int'(DEPTH); k++) begin
        dat_q[k] <= dat_d[k];
      end
    end
  end

  assign m_data_o = dat_q[DEPTH-1];
  assign occ_o    = occ_q;

endmodule

// File: tb/tb_my_reg_pipe.sv
// Bench for my_reg_pipe: word-level pipeline model predicts handshakes and
// occupancy; accepted words go into a scoreboard drained by an output monitor.
module tb_my_reg_pipe;
  localparam int unsigned       DATA_W  = 21;
  localparam int unsigned       DEPTH   = 3;
  localparam int unsigned       OCC_W   = $clog2(DEPTH + 1);
  localparam logic [DATA_W-1:0] RST_VAL = 21'h15A5A;

  logic              clk = 1'b0;
  logic              rst_i, en_i, flush_i, s_valid_i, m_ready_i;
  logic              s_ready_o, m_valid_o;
  logic [DATA_W-1:0] s_data_i, m_data_o;
  logic [OCC_W-1:0]  occ_o;

  always #5 clk = ~clk;

  my_reg_pipe #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RST_VAL(RST_VAL)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .flush_i(flush_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .occ_o(occ_o)
  );

  // Model: in-flight words in arrival order (head first) with their stage index.
  typedef struct { logic [DATA_W-1:0] d; int p; } word_t;
  word_t             mq[$];
  word_t             nq[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] last_dat;
  logic [DATA_W-1:0] nxt;
  int                n_checks = 0;
  int                n_fail   = 0;
  bit                known    = 1'b0;
  bit                acc;
  int                fed;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output monitor: every delivered word must be the oldest outstanding one.
  always @(negedge clk) begin
    if (known && m_valid_o === 1'b1 && m_ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out_unexpected: got %0h, expected no output (t=%0t)", m_data_o, $time);
      end else begin
        chk("out_data", 64'(m_data_o), 64'(exp_q.pop_front()));
      end
    end
  end

  // One clock cycle: drive, predict and check at negedge, advance model at posedge.
  task automatic step(input bit r, input bit f, input bit e, input bit sv,
                      input logic [DATA_W-1:0] d, input bit mr);
    bit go, mv, of, sr;
    int prev, np;
    rst_i = r; flush_i = f; en_i = e; s_valid_i = sv; s_data_i = d; m_ready_i = mr;
    @(negedge clk);
    go = e && !f && !r;
    mv = go && mq.size() > 0 && mq[0].p == int'(DEPTH) - 1;
    of = mv && mr;
    // Each word moves one stage on unless it would run into the word ahead.
    nq.delete();
    prev = int'(DEPTH);
    for (int i = (of ? 1 : 0); i < mq.size(); i++) begin
      np = (mq[i].p + 1 < prev - 1) ? mq[i].p + 1 : prev - 1;
      nq.push_back(word_t'{d: mq[i].d, p: np});
      prev = np;
    end
    sr  = go && (nq.size() == 0 || nq[nq.size()-1].p > 0);
    acc = sv && sr;
    chk("s_ready", 64'(s_ready_o), 64'(sr));
    chk("m_valid", 64'(m_valid_o), 64'(mv));
    chk("occ", 64'(occ_o), 64'(mq.size()));
    chk("m_data", 64'(m_data_o), 64'(last_dat));
    if (acc) exp_q.push_back(d);
    if (r || f) exp_q.delete();
    @(posedge clk);
    if (r) begin
      mq.delete();
      last_dat = RST_VAL;
    end else if (f) begin
      mq.delete();
    end else if (go) begin
      mq = nq;
      if (acc) mq.push_back(word_t'{d: d, p: 0});
      if (mq.size() > 0 && mq[0].p == int'(DEPTH) - 1) last_dat = mq[0].d;
    end
    #1;
  endtask

  task automatic idle(input int n, input bit mr);
    repeat (n) step(1'b0, 1'b0, 1'b1, 1'b0, '0, mr);
  endtask

  task automatic stream(input int n, input bit e, input bit mr);
    repeat (n) begin
      step(1'b0, 1'b0, e, 1'b1, nxt, mr);
      if (acc) nxt++;
    end
  endtask

  initial begin
    rst_i = 1'b1; en_i = 1'b1; flush_i = 1'b0; s_valid_i = 1'b1;
    s_data_i = '0; m_ready_i = 1'b1;
    @(posedge clk);
    #1;
    known    = 1'b1;
    last_dat = RST_VAL;
    nxt      = DATA_W'(1);

    // Reset held with input offered
    repeat (2) step(1'b1, 1'b0, 1'b1, 1'b1, nxt, 1'b1);

    // Back-to-back streaming
    stream(12, 1'b1, 1'b1);
    idle(5, 1'b1);

    // Back-pressure: five words offered against a stalled consumer
    fed = 0;
    repeat (6) begin
      step(1'b0, 1'b0, 1'b1, fed < 5, nxt, 1'b0);
      if (acc) begin nxt++; fed++; end
    end
    chk("bp_full_occ", 64'(occ_o), 64'(3));
    chk("bp_full_ready", 64'(s_ready_o), 64'(0));
    repeat (10) begin
      step(1'b0, 1'b0, 1'b1, fed < 5, nxt, 1'b1);
      if (acc) begin nxt++; fed++; end
    end
    idle(3, 1'b1);

    // Bubble collapse behind a stalled output
    stream(1, 1'b1, 1'b0);
    idle(2, 1'b0);
    stream(1, 1'b1, 1'b0);
    idle(3, 1'b0);
    chk("bubble_occ", 64'(occ_o), 64'(2));
    chk("bubble_ready", 64'(s_ready_o), 64'(1));
    idle(4, 1'b1);

    // Flush with simultaneous input and consumer ready
    stream(2, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, nxt, 1'b1);
    idle(5, 1'b1);

    // Enable stall mid-stream
    stream(4, 1'b1, 1'b1);
    stream(4, 1'b0, 1'b1);
    stream(8, 1'b1, 1'b1);
    idle(5, 1'b1);

    // Random traffic with occasional reset and flush
    repeat (400) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 90, $urandom_range(0, 99) < 70,
           DATA_W'($urandom), $urandom_range(0, 99) < 60);
    end
    idle(6, 1'b1);
    chk("sb_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
